// File: rtl/multiword_add_sequencer_pkg.sv
// Shared constants and state encoding for the multi-word add sequencer.
package multiword_add_sequencer_pkg;

  // Width of one adder slice; the external carry-lookahead adder is this wide.
  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/multiword_add_sequencer_slice_mux.sv
// Selects the 16-bit slice idx_i out of the latched A and B operands.
module multiword_add_sequencer_slice_mux
  import multiword_add_sequencer_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int IDXW  = $clog2(WORDS)
) (
  input  logic [SLICE_W*WORDS-1:0] a_i,
  input  logic [SLICE_W*WORDS-1:0] b_i,
  input  logic [IDXW-1:0]          idx_i,
  output logic [SLICE_W-1:0]       a_slice_o,
  output logic [SLICE_W-1:0]       b_slice_o
);

  logic [SLICE_W-1:0] a_words [WORDS];
  logic [SLICE_W-1:0] b_words [WORDS];

  // Split the wide operands into word arrays so selection is a plain array index.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_split
    assign a_words[gi] = a_i[gi*SLICE_W +: SLICE_W];
    assign b_words[gi] = b_i[gi*SLICE_W +: SLICE_W];
  end

  // idx never exceeds WORDS-1, so out-of-range entries are unreachable.
  assign a_slice_o = a_words[idx_i];
  assign b_slice_o = b_words[idx_i];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Sequences a WORDS x 16-bit add/subtract through an external 16-bit adder,
// least-significant slice first, chaining the carry through a register.
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W*WORDS-1:0] in_a,
  input  logic [SLICE_W*WORDS-1:0] in_b,
  input  logic                     in_cin,
  input  logic                     in_sub,
  output logic [SLICE_W-1:0]       add_a,
  output logic [SLICE_W-1:0]       add_b,
  output logic                     add_c0,
  input  logic [SLICE_W-1:0]       add_s,
  input  logic                     add_carry,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*WORDS-1:0] out_sum,
  output logic                     out_cout,
  output logic                     out_ovf
);

  localparam int W    = SLICE_W * WORDS;
  localparam int IDXW = $clog2(WORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [SLICE_W-1:0] a_slice, b_slice;
  logic [W-1:0]       sum_upd;
  logic               running;

  multiword_add_sequencer_slice_mux #(
    .WORDS (WORDS),
    .IDXW  (IDXW)
  ) u_slice_mux (
    .a_i       (a_q),
    .b_i       (b_q),
    .idx_i     (idx_q),
    .a_slice_o (a_slice),
    .b_slice_o (b_slice)
  );

  assign running   = (state_q == RUN);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

  // The adder inputs are quiet outside RUN so the external adder sees zeros.
  assign add_a  = running ? a_slice : '0;
  assign add_b  = running ? b_slice : '0;
  assign add_c0 = running & carry_q;

  // Result image with the current slice replaced by the adder sum.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_sum
    assign sum_upd[gi*SLICE_W +: SLICE_W] =
      (idx_q == IDXW'(gi)) ? add_s : sum_q[gi*SLICE_W +: SLICE_W];
  end

  // Next-state logic: accept in IDLE, one slice per cycle in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          // Subtraction is A + ~B + 1; carry-in is forced to 1 and in_cin ignored.
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub | in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = sum_upd;
        carry_d = add_carry;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_carry;
          // Signed overflow: carry out of the MSB differs from carry into it.
          ovf_d   = add_carry ^ (add_a[SLICE_W-1] ^ add_b[SLICE_W-1] ^ add_s[SLICE_W-1]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer with WORDS=4 and a behavioural 16-bit adder.
module tb_multiword_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic [15:0]  add_a;
  logic [15:0]  add_b;
  logic         add_c0;
  logic [15:0]  add_s;
  logic         add_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   n_checks    = 0;

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c0    (add_c0),
    .add_s     (add_s),
    .add_carry (add_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // 16-bit adder attached to the add_* ports
  logic [16:0] cla_full;
  assign cla_full  = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_c0};
  assign add_s     = cla_full[15:0];
  assign add_carry = cla_full[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word two's-complement arithmetic
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    logic [W:0] full;
    if (sub) begin
      e.sum  = a - b;
      e.cout = (a >= b);
      e.ovf  = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
    end else begin
      full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every output handshake against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result_count", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_sum", out_sum, e.sum);
        chk("out_cout", {63'd0, out_cout}, {63'd0, e.cout});
        chk("out_ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
        $display("result sum=%h cout=%0b ovf=%0b", out_sum, out_cout, out_ovf);
      end
    end
  end

  // Present one operation and return just after its accept edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    sb.push_back(model(a, b, cin, sub));
    vectors++;
    $display("op a=%h b=%h cin=%0b sub=%0b", a, b, cin, sub);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result, stall for 'hold' cycles, then take it
  task automatic finish_op(input int hold);
    int n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_timeout", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] snap_sum;
    logic         snap_cout;
    logic         snap_ovf;
    int           n;
    int           hold;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_sum", out_sum, 64'd0);
    chk("rst_out_cout_ovf", {62'd0, out_cout, out_ovf}, 64'd0);
    chk("rst_add_bus", {31'd0, add_a, add_b, add_c0}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: slice-0 carry into slice 1, exact latency
    send(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
    for (int k = 1; k <= WORDS; k++) begin
      @(posedge clk); #1;
      chk($sformatf("latency_out_valid_c%0d", k), {63'd0, out_valid}, {63'd0, (k == WORDS)});
    end
    finish_op(0);

    // 2: full ripple, carry seen on add_c0 in slices 1..3
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    chk("ripple_c0_slice0", {63'd0, add_c0}, 64'd0);
    for (int k = 1; k < WORDS; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ripple_c0_slice%0d", k), {63'd0, add_c0}, 64'd1);
    end
    finish_op(0);

    // 3: signed overflow via carry-in
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
    finish_op(0);

    // 4: subtraction, cin ignored
    send(64'd5, 64'd7, 1'b1, 1'b1);
    finish_op(0);
    send(64'd7, 64'd5, 1'b0, 1'b1);
    finish_op(0);

    // 5: backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    in_a = 64'hDEAD_BEEF_DEAD_BEEF; in_b = 64'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    snap_sum = out_sum; snap_cout = out_cout; snap_ovf = out_ovf;
    for (int k = 0; k < 3; k++) begin
      in_valid = (k == 1);
      @(posedge clk); #1;
      chk("bp_sum_stable", out_sum, snap_sum);
      chk("bp_flags_stable", {62'd0, out_cout, out_ovf}, {62'd0, snap_cout, snap_ovf});
      chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);

    // 6: asynchronous reset mid-RUN, then a clean operation
    send(64'hAAAA_5555_AAAA_5555, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_out_sum", out_sum, 64'd0);
    chk("arst_add_bus", {31'd0, add_a, add_b, add_c0}, 64'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(64'd1, 64'd2, 1'b0, 1'b0);
    finish_op(0);

    // Randomized operations with random output stalls
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = '1;
        1: rb = '0;
        2: ra = {1'b0, {(W-1){1'b1}}};
        3: rb = {1'b1, {(W-1){1'b0}}};
        default: ;
      endcase
      hold = $urandom_range(0, 3);
      out_ready = (hold == 0);
      send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      finish_op(hold);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
